// File: rtl/decodificador_teclas_if.sv
`default_nettype none
// ============================================================================
//  Module      : decodificador_teclas_if
//  Description : PS/2 byte input and decoded key-event outputs of the decoder.
//  Revision    : 1.0
// ============================================================================
interface decodificador_teclas_if;
   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;
   logic       tecla_arriba;
   logic       tecla_abajo;
   logic       frame_err;

   modport master (
      output rx_done_tick, rx_data,
      input  key_valid, key_code, key_ext, key_break,
      input  tecla_arriba, tecla_abajo, frame_err
   );

   modport slave (
      input  rx_done_tick, rx_data,
      output key_valid, key_code, key_ext, key_break,
      output tecla_arriba, tecla_abajo, frame_err
   );
endinterface
`default_nettype wire

// File: rtl/decodificador_teclas.sv
`default_nettype none
// ============================================================================
//  Module      : decodificador_teclas
//  Description : Strips E0/F0 prefixes from the PS/2 byte stream, suppresses
//                typematic repeats and emits registered key-event strobes.
//  Revision    : 1.0
// ============================================================================
module decodificador_teclas #(
   parameter logic [7:0]  UP_CODE        = 8'h1D,
   parameter logic [7:0]  DOWN_CODE      = 8'h1A,
   parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
   parameter bit          REPEAT_EN      = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   decodificador_teclas_if.slave bus
);

   localparam logic [1:0]  IDLE     = 2'd0;
   localparam logic [1:0]  EXT      = 2'd1;
   localparam logic [1:0]  BRK      = 2'd2;
   localparam logic [1:0]  EXT_BRK  = 2'd3;

   localparam logic [7:0]  C_PREFIX_EXT = 8'hE0;
   localparam logic [7:0]  C_PREFIX_BRK = 8'hF0;
   localparam logic [22:0] C_EXPIRE     = 23'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state_q,        state_d;
   logic [21:0] cnt_q,          cnt_d;
   logic [7:0]  held_code_q,    held_code_d;
   logic        held_ext_q,     held_ext_d;
   logic        held_vld_q,     held_vld_d;
   logic        key_valid_q,    key_valid_d;
   logic [7:0]  key_code_q,     key_code_d;
   logic        key_ext_q,      key_ext_d;
   logic        key_break_q,    key_break_d;
   logic        tecla_arriba_q, tecla_arriba_d;
   logic        tecla_abajo_q,  tecla_abajo_d;
   logic        frame_err_q,    frame_err_d;

   logic        evt_make;
   logic        evt_break;
   logic        evt_ext;
   logic        held_match;
   logic        report;
   logic        expire;

   // The tick cycle itself counts as the first waiting cycle, so the error
   // surfaces TIMEOUT_CYCLES cycles after the prefix tick.
   assign expire = (({1'b0, cnt_q} + 23'd1) >= C_EXPIRE);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      held_code_d    = held_code_q;
      held_ext_d     = held_ext_q;
      held_vld_d     = held_vld_q;
      key_valid_d    = 1'b0;
      key_code_d     = key_code_q;
      key_ext_d      = key_ext_q;
      key_break_d    = key_break_q;
      tecla_arriba_d = 1'b0;
      tecla_abajo_d  = 1'b0;
      frame_err_d    = 1'b0;
      evt_make       = 1'b0;
      evt_break      = 1'b0;
      evt_ext        = 1'b0;

      if (bus.rx_done_tick) begin
         cnt_d = '0;
         case (state_q)
            IDLE: begin
               if (bus.rx_data == C_PREFIX_EXT)      state_d = EXT;
               else if (bus.rx_data == C_PREFIX_BRK) state_d = BRK;
               else                                  evt_make = 1'b1;
            end
            EXT: begin
               if (bus.rx_data == C_PREFIX_BRK)      state_d = EXT_BRK;
               else if (bus.rx_data == C_PREFIX_EXT) state_d = EXT;
               else begin
                  evt_make = 1'b1;
                  evt_ext  = 1'b1;
               end
            end
            BRK, EXT_BRK: begin
               if ((bus.rx_data == C_PREFIX_EXT) || (bus.rx_data == C_PREFIX_BRK)) begin
                  frame_err_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  evt_break = 1'b1;
                  evt_ext   = (state_q == EXT_BRK);
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         if (expire) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
         end else begin
            cnt_d = cnt_q + 22'd1;
         end
      end

      if (evt_make || evt_break) state_d = IDLE;

      held_match = held_vld_q && (held_code_q == bus.rx_data) && (held_ext_q == evt_ext);
      report     = evt_break || (evt_make && (!held_match || REPEAT_EN));

      if (report) begin
         key_valid_d = 1'b1;
         key_code_d  = bus.rx_data;
         key_ext_d   = evt_ext;
         key_break_d = evt_break;
      end

      // Up wins if both codes are configured equal, keeping the strobes exclusive.
      if (report && evt_make && !evt_ext) begin
         tecla_arriba_d = (bus.rx_data == UP_CODE);
         tecla_abajo_d  = (bus.rx_data == DOWN_CODE) && (bus.rx_data != UP_CODE);
      end

      if (evt_make && !held_match) begin
         held_code_d = bus.rx_data;
         held_ext_d  = evt_ext;
         held_vld_d  = 1'b1;
      end
      if (evt_break && held_match) held_vld_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         held_code_q    <= '0;
         held_ext_q     <= 1'b0;
         held_vld_q     <= 1'b0;
         key_valid_q    <= 1'b0;
         key_code_q     <= '0;
         key_ext_q      <= 1'b0;
         key_break_q    <= 1'b0;
         tecla_arriba_q <= 1'b0;
         tecla_abajo_q  <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         held_code_q    <= held_code_d;
         held_ext_q     <= held_ext_d;
         held_vld_q     <= held_vld_d;
         key_valid_q    <= key_valid_d;
         key_code_q     <= key_code_d;
         key_ext_q      <= key_ext_d;
         key_break_q    <= key_break_d;
         tecla_arriba_q <= tecla_arriba_d;
         tecla_abajo_q  <= tecla_abajo_d;
         frame_err_q    <= frame_err_d;
      end
   end

   assign bus.key_valid    = key_valid_q;
   assign bus.key_code     = key_code_q;
   assign bus.key_ext      = key_ext_q;
   assign bus.key_break    = key_break_q;
   assign bus.tecla_arriba = tecla_arriba_q;
   assign bus.tecla_abajo  = tecla_abajo_q;
   assign bus.frame_err    = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_decodificador_teclas.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decodificador_teclas
//  Description : Directed scoreboard bench for the PS/2 key-event decoder.
//  Revision    : 1.0
// ============================================================================
module tb_decodificador_teclas;

   typedef struct {
      int          cyc;
      logic [13:0] vec;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;
   int   b_abajo = 0;
   exp_t exp_q[$];
   exp_t e;
   logic [7:0] m_code = 8'h00;
   logic       m_ext  = 1'b0;
   logic       m_brk  = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   decodificador_teclas_if ifa ();
   decodificador_teclas_if ifb ();

   decodificador_teclas #(.TIMEOUT_CYCLES(16)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   decodificador_teclas #(.REPEAT_EN(1'b1)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   function automatic logic [13:0] pack_a();
      return {ifa.key_valid, ifa.key_code, ifa.key_ext, ifa.key_break,
              ifa.tecla_arriba, ifa.tecla_abajo, ifa.frame_err};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Any pulse on dut_a must match the oldest pending expectation, in value and cycle.
   always @(negedge clk) begin
      if (ifa.key_valid || ifa.tecla_arriba || ifa.tecla_abajo || ifa.frame_err) begin
         n_assert++;
         assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_pulse: observed %h at cycle %0d expected no pulse", pack_a(), cyc);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("event_vec", {18'd0, pack_a()}, {18'd0, e.vec});
            chk("event_cycle", cyc, e.cyc);
         end
      end
      if (ifb.tecla_abajo) b_abajo++;
   end

   task automatic send(input logic [7:0] b);
      ifa.rx_data      = b;
      ifa.rx_done_tick = 1'b1;
      @(posedge clk); #1;
      ifa.rx_done_tick = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] b);
      ifb.rx_data      = b;
      ifb.rx_done_tick = 1'b1;
      @(posedge clk); #1;
      ifb.rx_done_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_evt(input int c, input logic [7:0] code, input logic ext,
                          input logic brk, input logic up, input logic dn);
      m_code = code;
      m_ext  = ext;
      m_brk  = brk;
      exp_q.push_back('{c, {1'b1, code, ext, brk, up, dn, 1'b0}});
   endtask

   task automatic exp_err(input int c);
      exp_q.push_back('{c, {1'b0, m_code, m_ext, m_brk, 1'b0, 1'b0, 1'b1}});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int c;
      reset = 1'b1;
      ifa.rx_done_tick = 1'b0; ifa.rx_data = 8'h00;
      ifb.rx_done_tick = 1'b0; ifb.rx_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {18'd0, pack_a()}, 32'd0);
      reset = 1'b0;
      idle(2);

      // make then break of the up key
      exp_evt(cyc + 1, 8'h1D, 1'b0, 1'b0, 1'b1, 1'b0);
      send(8'h1D); idle(2);
      send(8'hF0);
      exp_evt(cyc + 1, 8'h1D, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h1D); idle(2);

      // typematic repeat of the down key is suppressed
      exp_evt(cyc + 1, 8'h1A, 1'b0, 1'b0, 1'b0, 1'b1);
      send(8'h1A); idle(2);
      send(8'h1A); idle(2);
      send(8'h1A); idle(2);
      send(8'hF0);
      exp_evt(cyc + 1, 8'h1A, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h1A); idle(2);

      // extended make/break, extended up code gives no strobe
      send(8'hE0);
      exp_evt(cyc + 1, 8'h75, 1'b1, 1'b0, 1'b0, 1'b0);
      send(8'h75); idle(2);
      send(8'hE0); send(8'hF0);
      exp_evt(cyc + 1, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0);
      send(8'h75); idle(2);
      send(8'hE0);
      exp_evt(cyc + 1, 8'h1D, 1'b1, 1'b0, 1'b0, 1'b0);
      send(8'h1D); idle(2);

      // double break prefix is a framing error and returns to IDLE
      send(8'hF0);
      exp_err(cyc + 1);
      send(8'hF0); idle(3);
      exp_evt(cyc + 1, 8'h1A, 1'b0, 1'b0, 1'b0, 1'b1);
      send(8'h1A); idle(2);
      send(8'hF0);
      exp_evt(cyc + 1, 8'h1A, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h1A); idle(2);

      // prefix timeout 16 cycles after the F0 tick
      c = cyc;
      exp_err(c + 16);
      send(8'hF0); idle(20);
      exp_evt(cyc + 1, 8'h1D, 1'b0, 1'b0, 1'b1, 1'b0);
      send(8'h1D); idle(2);

      // reset mid-sequence discards the prefix and the held key
      send(8'hF0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("reset_mid_outputs", {18'd0, pack_a()}, 32'd0);
      m_code = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
      reset = 1'b0;
      exp_evt(cyc + 1, 8'h1D, 1'b0, 1'b0, 1'b1, 1'b0);
      send(8'h1D); idle(2);
      send(8'hF0);
      exp_evt(cyc + 1, 8'h1D, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h1D); idle(2);

      // back-to-back ticks
      c = cyc;
      exp_evt(c + 1, 8'h1D, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_evt(c + 3, 8'h1D, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h1D); send(8'hF0); send(8'h1D); idle(3);

      // tick landing on the expiry cycle is decoded, no timeout error
      send(8'hF0); idle(14);
      exp_evt(cyc + 1, 8'h2B, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h2B); idle(20);

      // repeats reported as presses when enabled
      send_b(8'h1A); idle(2);
      send_b(8'h1A); idle(2);
      send_b(8'h1A); idle(3);
      chk("repeat_en_abajo_count", b_abajo, 32'd3);

      idle(5);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
